// File: rtl/vga_timing_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_if
// Description : Raster timing bundle: advance enable in, position/strobes out.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_if;
    logic        pix_en;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic        frame_start;

    modport master (
        input  pix_en,
        output hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start
    );

    modport slave (
        output pix_en,
        input  hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start
    );
endinterface
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing
// Description : Free-running raster counter with registered sync/blank strobes
//               and a frame-start pulse, all aligned to the same position.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing #(
    parameter int   H_ACTIVE     = 1024,
    parameter int   H_TOTAL      = 1344,
    parameter int   H_SYNC_START = 1048,
    parameter int   H_SYNC_W     = 136,
    parameter int   V_ACTIVE     = 768,
    parameter int   V_TOTAL      = 806,
    parameter int   V_SYNC_START = 771,
    parameter int   V_SYNC_W     = 6,
    parameter logic SYNC_POL     = 1'b0
) (
    input  wire logic     pclk,
    input  wire logic     rst_n,
    vga_timing_if.master  bus
);

    localparam logic [10:0] c_H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] c_V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] c_H_ACTIVE   = 11'(H_ACTIVE);
    localparam logic [10:0] c_V_ACTIVE   = 11'(V_ACTIVE);
    localparam logic [10:0] c_HS_START   = 11'(H_SYNC_START);
    localparam logic [10:0] c_HS_END     = 11'(H_SYNC_START + H_SYNC_W);
    localparam logic [10:0] c_VS_START   = 11'(V_SYNC_START);
    localparam logic [10:0] c_VS_END     = 11'(V_SYNC_START + V_SYNC_W);

    logic [10:0] hcount_q, hcount_d;
    logic [10:0] vcount_q, vcount_d;
    logic        hsync_q,  hsync_d;
    logic        vsync_q,  vsync_d;
    logic        hblnk_q,  hblnk_d;
    logic        vblnk_q,  vblnk_d;
    logic        fstart_q, fstart_d;

    // Strobes decode the next position so they land in the same edge as the counters.
    always_comb begin
        hcount_d = (hcount_q == c_H_LAST) ? 11'd0 : hcount_q + 11'd1;
        vcount_d = vcount_q;
        if (hcount_q == c_H_LAST) begin
            vcount_d = (vcount_q == c_V_LAST) ? 11'd0 : vcount_q + 11'd1;
        end
        hblnk_d  = (hcount_d >= c_H_ACTIVE);
        vblnk_d  = (vcount_d >= c_V_ACTIVE);
        hsync_d  = ((hcount_d >= c_HS_START) && (hcount_d < c_HS_END)) ? SYNC_POL : ~SYNC_POL;
        vsync_d  = ((vcount_d >= c_VS_START) && (vcount_d < c_VS_END)) ? SYNC_POL : ~SYNC_POL;
        fstart_d = (hcount_d == 11'd0) && (vcount_d == 11'd0);
    end

    // Reset loads (0,0) directly, so frame_start only fires on a real wrap.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            hcount_q <= 11'd0;
            vcount_q <= 11'd0;
            hsync_q  <= ~SYNC_POL;
            vsync_q  <= ~SYNC_POL;
            hblnk_q  <= 1'b0;
            vblnk_q  <= 1'b0;
            fstart_q <= 1'b0;
        end else if (bus.pix_en) begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            hblnk_q  <= hblnk_d;
            vblnk_q  <= vblnk_d;
            fstart_q <= fstart_d;
        end
    end

    assign bus.hcount      = hcount_q;
    assign bus.vcount      = vcount_q;
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.hblnk       = hblnk_q;
    assign bus.vblnk       = vblnk_q;
    assign bus.frame_start = fstart_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing
// Description : Scoreboard bench for vga_timing on a shrunken raster, with a
//               negative- and a positive-polarity instance side by side.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing;

    localparam int HA  = 16;
    localparam int HT  = 24;
    localparam int HSS = 18;
    localparam int HSW = 3;
    localparam int VA  = 6;
    localparam int VT  = 9;
    localparam int VSS = 7;
    localparam int VSW = 1;
    localparam int FRAME = HT * VT;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hb;
        logic        vb;
        logic        hs0;
        logic        vs0;
        logic        hs1;
        logic        vs1;
        logic        fs;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t sb_q[$];
    int   vectors;
    int   miscompares;
    int   p;
    logic fs;

    vga_timing_if bus0 ();
    vga_timing_if bus1 ();

    vga_timing #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .H_SYNC_START(HSS), .H_SYNC_W(HSW),
        .V_ACTIVE(VA), .V_TOTAL(VT), .V_SYNC_START(VSS), .V_SYNC_W(VSW),
        .SYNC_POL(1'b0)
    ) u_dut_neg (
        .pclk  (clk),
        .rst_n (rst_n),
        .bus   (bus0.master)
    );

    vga_timing #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .H_SYNC_START(HSS), .H_SYNC_W(HSW),
        .V_ACTIVE(VA), .V_TOTAL(VT), .V_SYNC_START(VSS), .V_SYNC_W(VSW),
        .SYNC_POL(1'b1)
    ) u_dut_pos (
        .pclk  (clk),
        .rst_n (rst_n),
        .bus   (bus1.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs derive from a linear raster index, not from h/v counters.
    function automatic exp_t expect_at(input int pos, input logic fstart);
        exp_t e;
        int   h, v;
        logic hact, vact;
        h     = pos % HT;
        v     = pos / HT;
        hact  = (h >= HSS) && (h < HSS + HSW);
        vact  = (v >= VSS) && (v < VSS + VSW);
        e.h   = 11'(h);
        e.v   = 11'(v);
        e.hb  = (h >= HA);
        e.vb  = (v >= VA);
        e.hs0 = ~hact;
        e.vs0 = ~vact;
        e.hs1 = hact;
        e.vs1 = vact;
        e.fs  = fstart;
        return e;
    endfunction

    task automatic step(input logic r, input logic en);
        @(negedge clk);
        rst_n       = r;
        bus0.pix_en = en;
        bus1.pix_en = en;
        if (!r) begin
            p  = 0;
            fs = 1'b0;
        end else if (en) begin
            p  = (p + 1) % FRAME;
            fs = (p == 0);
        end
        sb_q.push_back(expect_at(p, fs));
    endtask

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        while (p != target && guard < 2 * FRAME) begin
            step(1'b1, 1'b1);
            guard++;
        end
    endtask

    task automatic chk(input string name, input logic [10:0] act, input logic [10:0] req);
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s at vector %0d: got %0d, expected %0d", name, vectors, act, req);
        end
    endtask

    // Monitor: every output is registered, so each edge presents a new vector.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                vectors++;
                chk("hcount",      bus0.hcount,             e.h);
                chk("vcount",      bus0.vcount,             e.v);
                chk("hblnk",       11'(bus0.hblnk),         11'(e.hb));
                chk("vblnk",       11'(bus0.vblnk),         11'(e.vb));
                chk("hsync_neg",   11'(bus0.hsync),         11'(e.hs0));
                chk("vsync_neg",   11'(bus0.vsync),         11'(e.vs0));
                chk("frame_start", 11'(bus0.frame_start),   11'(e.fs));
                chk("hcount_pos",  bus1.hcount,             e.h);
                chk("hsync_pos",   11'(bus1.hsync),         11'(e.hs1));
                chk("vsync_pos",   11'(bus1.vsync),         11'(e.vs1));
                chk("fstart_pos",  11'(bus1.frame_start),   11'(e.fs));
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        p           = 0;
        fs          = 1'b0;
        rst_n       = 1'b0;
        bus0.pix_en = 1'b1;
        bus1.pix_en = 1'b1;

        repeat (5) step(1'b0, 1'b1);
        // Release: first enabled edge lands on hcount=1.
        step(1'b1, 1'b1);

        // Mid-line stall, then resume.
        run_to(1 * HT + 12);
        repeat (7) step(1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b1);

        // Frame wrap with frame_start held through a stall.
        run_to(0);
        repeat (7) step(1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b1);

        // Mid-frame reset, including reset while stalled.
        run_to(VSS * HT + HSS + 1);
        repeat (3) step(1'b0, 1'b1);
        repeat (2) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (4) step(1'b1, 1'b1);

        // Two clean frames through the full vertical sync/blank window.
        run_to(0);
        run_to(FRAME - 1);
        run_to(0);
        repeat (HT + 2) step(1'b1, 1'b1);

        repeat (3) @(negedge clk);
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d vectors unchecked, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
